// File: rtl/sram_port_arbiter_if.sv
// CPU, video and SRAM pad signals of the SRAM port arbiter.
// slave is the arbiter's view; master is the bus-master/pad view.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              cpu_stb;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_din;
    logic [31:0]       cpu_dout;
    logic              cpu_ack;

    logic              vid_stb;
    logic              vid_we;
    logic [ADDR_W-1:0] vid_addr;
    logic [15:0]       vid_din;
    logic [15:0]       vid_dout;
    logic              vid_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [47:0]       mem_wdata;
    logic [47:0]       mem_rdata;

    modport slave (
        input  cpu_stb, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  vid_stb, vid_we, vid_addr, vid_din,
        output vid_dout, vid_ack,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_stb, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output vid_stb, vid_we, vid_addr, vid_din,
        input  vid_dout, vid_ack,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one 48-bit SRAM between VGA scan, CPU (lanes 31:0) and video (lanes 47:32) ports.
// Define SRAM_INIT_EN to add a post-reset sweep that clears INIT_LEN words from INIT_BASE.
module sram_port_arbiter #(
`ifdef SRAM_INIT_EN
    parameter int unsigned INIT_BASE = 'h80000,
    parameter int unsigned INIT_LEN  = 128,
    parameter logic [47:0] INIT_WORD = 48'h000008080000,
`endif
    parameter int unsigned ADDR_W    = 20
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              scan_phase,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [15:0]       scan_data,
    output logic              busy,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
`ifdef SRAM_INIT_EN
        StInit,
`endif
        StAck
    } state_e;

    localparam logic GntCpu = 1'b0;
    localparam logic GntVid = 1'b1;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       din_q, din_d;
    logic [47:0]       rd_word_q, rd_word_d;
    logic [31:0]       cpu_dout_q, cpu_dout_d;
    logic [15:0]       vid_dout_q, vid_dout_d;
    logic [15:0]       scan_data_q;

`ifdef SRAM_INIT_EN
    localparam int unsigned CntW = $clog2(INIT_LEN + 1);
    logic [CntW-1:0] init_cnt_q, init_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_last_d     = rr_last_q;
        addr_d        = addr_q;
        we_d          = we_q;
        din_d         = din_q;
        rd_word_d     = rd_word_q;
        cpu_dout_d    = cpu_dout_q;
        vid_dout_d    = vid_dout_q;
        bus.mem_addr  = addr_q;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = (grant_q == GntCpu) ? {rd_word_q[47:32], din_q}
                                            : {din_q[15:0], rd_word_q[31:0]};
        bus.cpu_ack   = 1'b0;
        bus.vid_ack   = 1'b0;
`ifdef SRAM_INIT_EN
        init_cnt_d    = init_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.cpu_stb || bus.vid_stb) begin
                    // On a tie the port that was not served last wins.
                    grant_d = (bus.cpu_stb && bus.vid_stb) ? ~rr_last_q : bus.vid_stb;
                    addr_d  = (grant_d == GntVid) ? bus.vid_addr : bus.cpu_addr;
                    we_d    = (grant_d == GntVid) ? bus.vid_we : bus.cpu_we;
                    din_d   = (grant_d == GntVid) ? {16'h0000, bus.vid_din} : bus.cpu_din;
                    state_d = StRd;
                end
            end
            StRd: begin
                if (!scan_phase) begin
                    rd_word_d = bus.mem_rdata;
                    if (!we_q) begin
                        if (grant_q == GntCpu) cpu_dout_d = bus.mem_rdata[31:0];
                        else                   vid_dout_d = bus.mem_rdata[47:32];
                    end
                    state_d = we_q ? StWr : StAck;
                end
            end
            StWr: begin
                if (!scan_phase) begin
                    bus.mem_we = 1'b1;
                    state_d    = StAck;
                end
            end
            StAck: begin
                bus.cpu_ack = (grant_q == GntCpu);
                bus.vid_ack = (grant_q == GntVid);
                rr_last_d   = grant_q;
                state_d     = StIdle;
            end
`ifdef SRAM_INIT_EN
            StInit: begin
                bus.mem_addr  = ADDR_W'(INIT_BASE) + ADDR_W'(init_cnt_q);
                bus.mem_wdata = INIT_WORD;
                if (!scan_phase) begin
                    bus.mem_we = 1'b1;
                    init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == CntW'(INIT_LEN - 1)) state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Scan owns odd slots outright; reset must never let a write reach the pads.
        if (scan_phase) begin
            bus.mem_addr = scan_addr;
            bus.mem_we   = 1'b0;
        end
        if (rst) bus.mem_we = 1'b0;
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
`ifdef SRAM_INIT_EN
            state_q    <= StInit;
            init_cnt_q <= '0;
`else
            state_q    <= StIdle;
`endif
            grant_q     <= GntCpu;
            rr_last_q   <= GntVid;
            addr_q      <= '0;
            we_q        <= 1'b0;
            din_q       <= '0;
            rd_word_q   <= '0;
            cpu_dout_q  <= '0;
            vid_dout_q  <= '0;
            scan_data_q <= '0;
        end else begin
            state_q    <= state_d;
`ifdef SRAM_INIT_EN
            init_cnt_q <= init_cnt_d;
`endif
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            din_q      <= din_d;
            rd_word_q  <= rd_word_d;
            cpu_dout_q <= cpu_dout_d;
            vid_dout_q <= vid_dout_d;
            if (scan_phase) scan_data_q <= bus.mem_rdata[47:32];
        end
    end

    assign bus.cpu_dout = cpu_dout_q;
    assign bus.vid_dout = vid_dout_q;
    assign scan_data    = scan_data_q;
    assign busy         = (state_q != StIdle);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an SRAM model and an ack scoreboard.
module tb_sram_port_arbiter;
    localparam int unsigned ADDR_W = 20;

    logic              clk_50mhz = 1'b0;
    logic              rst = 1'b1;
    logic              scan_phase = 1'b0;
    logic [ADDR_W-1:0] scan_addr = 20'h80005;
    logic [15:0]       scan_data;
    logic              busy;

    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [47:0]       poke_data = '0;
    logic [47:0]       mem [0:1023];

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int cpu_ack_cnt = 0;
    int vid_ack_cnt = 0;

    typedef struct {
        bit          port;
        bit          is_rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sram_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .scan_phase (scan_phase),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .busy       (busy),
        .bus        (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    function automatic logic [9:0] idx(input logic [ADDR_W-1:0] a);
        return {a[19], a[8:0]};
    endfunction

    assign bus.mem_rdata = mem[idx(bus.mem_addr)];

    always @(posedge clk_50mhz) begin
        scan_phase <= ~scan_phase;
        if (poke_en) mem[idx(poke_addr)] <= poke_data;
        else if (bus.mem_we) mem[idx(bus.mem_addr)] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: write strobes must avoid scan slots, acks must match the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_50mhz);
            if (bus.mem_we) begin
                we_cnt++;
                check("we_in_scan", {47'b0, scan_phase}, 48'h0);
            end
            if (bus.cpu_ack || bus.vid_ack) begin
                if (bus.cpu_ack) cpu_ack_cnt++;
                if (bus.vid_ack) vid_ack_cnt++;
                check("ack_overlap", {47'b0, bus.cpu_ack & bus.vid_ack}, 48'h0);
                check("sb_nonempty", {47'b0, sb.size() != 0}, 48'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ack_port", {47'b0, bus.vid_ack}, {47'b0, e.port});
                    if (e.is_rd)
                        check("rd_data", e.port ? {32'b0, bus.vid_dout} : {16'b0, bus.cpu_dout},
                              {16'b0, e.data});
                end
            end
        end
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [47:0] d);
        @(negedge clk_50mhz);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk_50mhz);
        #1 poke_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) @(negedge clk_50mhz);
        check("busy_timeout", {47'b0, busy}, 48'h0);
    endtask

    task automatic do_reset();
        @(negedge clk_50mhz);
        rst = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        rst = 1'b0;
    endtask

    task automatic req(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] din, input logic [31:0] exp_rd);
        bit got = 1'b0;
        @(negedge clk_50mhz);
        if (port) begin
            bus.vid_stb = 1'b1; bus.vid_we = we; bus.vid_addr = addr; bus.vid_din = din[15:0];
        end else begin
            bus.cpu_stb = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = din;
        end
        sb.push_back('{port, !we, exp_rd});
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_50mhz);
            got = port ? bus.vid_ack : bus.cpu_ack;
        end
        check("ack_timeout", {47'b0, got}, 48'h1);
        if (port) bus.vid_stb = 1'b0;
        else      bus.cpu_stb = 1'b0;
    endtask

    initial begin
        int base_we;
        int base_ack;
        int acks;
        bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.vid_stb = 1'b0; bus.vid_we = 1'b0; bus.vid_addr = '0; bus.vid_din = '0;

        // Reset state, sampled while rst is still high.
        repeat (3) @(negedge clk_50mhz);
        check("rst_cpu_ack", {47'b0, bus.cpu_ack}, 48'h0);
        check("rst_vid_ack", {47'b0, bus.vid_ack}, 48'h0);
        check("rst_cpu_dout", {16'b0, bus.cpu_dout}, 48'h0);
        check("rst_vid_dout", {32'b0, bus.vid_dout}, 48'h0);
        check("rst_scan_data", {32'b0, scan_data}, 48'h0);
        check("rst_mem_we", {47'b0, bus.mem_we}, 48'h0);
`ifdef SRAM_INIT_EN
        check("rst_busy", {47'b0, busy}, 48'h1);
`else
        check("rst_busy", {47'b0, busy}, 48'h0);
`endif
        poke(20'h00010, 48'hAAAA_1234_5678);
        rst = 1'b0;

`ifdef SRAM_INIT_EN
        // Init sweep: a CPU read held across it must wait for busy to fall.
        base_we  = we_cnt;
        base_ack = cpu_ack_cnt;
        bus.cpu_stb = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00010;
        sb.push_back('{1'b0, 1'b1, 32'h1234_5678});
        for (int i = 0; i < 400 && busy; i++) @(negedge clk_50mhz);
        check("init_busy_fall", {47'b0, busy}, 48'h0);
        check("init_slots", 48'(we_cnt - base_we), 48'd128);
        check("init_no_early_ack", 48'(cpu_ack_cnt - base_ack), 48'h0);
        for (int i = 0; i < 40 && cpu_ack_cnt == base_ack; i++) @(negedge clk_50mhz);
        check("init_held_ack", 48'(cpu_ack_cnt - base_ack), 48'h1);
        bus.cpu_stb = 1'b0;
        for (int n = 0; n < 128; n++)
            check("init_word", mem[idx(20'h80000 + 20'(n))], 48'h0000_0808_0000);
`else
        wait_idle();
`endif

        // CPU read, then partial-lane writes and read-backs on the same word.
        base_we = we_cnt;
        req(1'b0, 1'b0, 20'h00010, 32'h0, 32'h1234_5678);
        check("rd_no_we", 48'(we_cnt - base_we), 48'h0);
        base_we = we_cnt;
        req(1'b1, 1'b1, 20'h00010, 32'h0000_BEEF, 32'h0);
        check("vid_wr_word", mem[idx(20'h00010)], 48'hBEEF_1234_5678);
        check("vid_wr_one_we", 48'(we_cnt - base_we), 48'h1);
        req(1'b1, 1'b0, 20'h00010, 32'h0, 32'h0000_BEEF);
        req(1'b0, 1'b1, 20'h00010, 32'hCAFE_F00D, 32'h0);
        check("cpu_wr_word", mem[idx(20'h00010)], 48'hBEEF_CAFE_F00D);
        req(1'b0, 1'b0, 20'h00010, 32'h0, 32'hCAFE_F00D);

        // Both ports held from reset: grants must alternate CPU, VID, CPU, VID.
        poke(20'h00020, 48'h2222_AAAA_0001);
        poke(20'h00030, 48'h3333_BBBB_0002);
        do_reset();
        bus.cpu_stb = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00020;
        bus.vid_stb = 1'b1; bus.vid_we = 1'b0; bus.vid_addr = 20'h00030;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{1'b0, 1'b1, 32'hAAAA_0001});
            sb.push_back('{1'b1, 1'b1, 32'h0000_3333});
        end
        acks = 0;
        for (int i = 0; i < 600 && acks < 4; i++) begin
            @(negedge clk_50mhz);
            if (bus.cpu_ack || bus.vid_ack) acks++;
        end
        bus.cpu_stb = 1'b0;
        bus.vid_stb = 1'b0;
        check("rr_ack_count", 48'(acks), 48'd4);
        check("rr_sb_drained", 48'(sb.size()), 48'h0);

        // Scan path: scan_data follows the word at scan_addr one cycle after each scan slot.
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            poke(20'h80005, (k == 0) ? 48'h0808_1111_2222 : 48'h5A5A_3333_4444);
            repeat (3) @(negedge clk_50mhz);
            if (scan_phase) @(negedge clk_50mhz);
            check("scan_data", {32'b0, scan_data}, (k == 0) ? 48'h0808 : 48'h5A5A);
        end

        // Reset during the WR-wait cycle, then during the WR slot itself.
        poke(20'h00040, 48'h4444_5555_6666);
        for (int v = 0; v < 2; v++) begin
            base_ack = cpu_ack_cnt;
            @(negedge clk_50mhz);
            if (!scan_phase) @(negedge clk_50mhz);
            bus.cpu_stb = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 20'h00040;
            bus.cpu_din = 32'hDEAD_BEEF;
            repeat (2 + v) @(posedge clk_50mhz);
            #1 rst = 1'b1;
            bus.cpu_stb = 1'b0;
            @(posedge clk_50mhz);
            #1 rst = 1'b0;
            wait_idle();
            repeat (4) @(negedge clk_50mhz);
            check("abort_mem", mem[idx(20'h00040)], 48'h4444_5555_6666);
            check("abort_no_ack", 48'(cpu_ack_cnt - base_ack), 48'h0);
        end
        req(1'b0, 1'b0, 20'h00040, 32'h0, 32'h5555_6666);
        req(1'b0, 1'b1, 20'h00040, 32'h1234_5678, 32'h0);
        check("post_abort_wr", mem[idx(20'h00040)], 48'h4444_1234_5678);

        repeat (4) @(negedge clk_50mhz);
        check("sb_final", 48'(sb.size()), 48'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Arbitrates the single 48-bit external SRAM between the CPU port (lanes [31:0]), the video-write port (lanes [47:32]) and the VGA scan read.
- Scan owns every cycle with scan_phase=1.
- CPU and video transactions share the scan_phase=0 slots under round-robin arbitration.
- Partial-lane writes are done as read-merge-write so that the other port's lanes are preserved.
- Sits between the CPU/VRAM bus masters and the SRAM pad drivers.

Parameters:
- ADDR_W, 20, SRAM word address width.
- INIT_BASE, 20'h80000, first word cleared by the optional init sweep.
- INIT_LEN, 128, number of words cleared by the init sweep.
- INIT_WORD, 48'h000008080000, fill value written by the init sweep.

Ports:
- clk_50mhz  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- scan_phase  in  1  1 = scan cycle, 0 = arbitrated slot; toggles every clock.
- scan_addr  in  ADDR_W  VGA scan word address.
- scan_data  out  16  registered mem_rdata[47:32] from the last scan cycle.
- cpu_stb  in  1  CPU request; held until cpu_ack.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_din  in  32  CPU write data.
- cpu_dout  out  32  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- vid_stb, vid_we, vid_addr, vid_din[15:0], vid_dout[15:0], vid_ack  as the CPU port, for the video port.
- mem_addr  out  ADDR_W  SRAM address.
- mem_we  out  1  SRAM write strobe; pads derive WEN/OEN from it.
- mem_wdata  out  48  SRAM write data.
- mem_rdata  in  48  SRAM read data; asynchronous, valid within the cycle.
- busy  out  1  1 while a transaction or the init sweep is active.

Behaviour:
Reset values:
- state=IDLE, cpu_ack=vid_ack=0, cpu_dout=vid_dout=0, scan_data=0.
- rr_last=VID, so the CPU wins the first tie.
- mem_we=0, busy=0.

Datapath during scan and reset:
- mem_we is forced to 0 whenever rst=1 or scan_phase=1.
- In scan_phase=1 cycles: mem_addr=scan_addr, and scan_data<=mem_rdata[47:32] at the closing posedge.

FSM states: IDLE, RD, WR, ACK, plus INIT when the optional feature is enabled.
- IDLE: any stb high → register grant, addr, we and din → RD.
  - Both stb high: grant the port not equal to rr_last.
  - busy=1 from RD through ACK.
- RD: waits for a scan_phase=0 cycle. In that cycle, mem_addr=granted addr and mem_we=0. At the closing posedge:
  - latch rd_word<=mem_rdata;
  - go to WR if we=1, else ACK.
- WR: waits for a scan_phase=0 cycle. In that cycle, mem_we=1 and mem_wdata is the merged word:
  - CPU grant: {rd_word[47:32], din[31:0]}.
  - Video grant: {din[15:0], rd_word[31:0]}.
  - Next state: ACK.
- ACK: granted ack=1 for exactly one cycle; rr_last<=grant.
  - Read: cpu_dout<=rd_word[31:0] or vid_dout<=rd_word[47:32], valid from the ack cycle and held until that port's next read completes.
  - Next state: IDLE.

Latency and fairness:
- From IDLE with the grant slot aligned: read ack at cycle 3, write ack at cycle 5.
- Misalignment with scan_phase adds at most 1 cycle per memory access.
- Back-to-back requests from both ports alternate strictly.

Handshake rules:
- stb is sampled only in IDLE. Dropping stb after grant does not abort; ack still pulses.
- A requester with stb held high after its ack may be re-granted only after IDLE.

Boundary conditions:
- Address is passed through; no wrap or bounds check.
- rst mid-transaction: the transaction is abandoned, no ack, mem_we=0 in the rst cycle, and any pending write is never issued.

Optional Feature:
SRAM_INIT_EN
- Defined: after rst deasserts, state=INIT and busy=1; no grants; stb is ignored but held.
  - Each scan_phase=0 slot writes INIT_WORD to INIT_BASE+n, for n=0..INIT_LEN-1, one word per slot.
  - After the last word → IDLE.
  - Scan cycles are still served during INIT.
- Undefined: reset goes directly to IDLE; the INIT state and its counter are absent.

Test Plan:
1. CPU read, addr=0x00010, mem model word 0xAAAA_1234_5678 → cpu_ack pulses once; cpu_dout=0x12345678; mem_we never high.
2. Video write 0xBEEF to 0x00010, word previously 0xAAAA_1234_5678 → final word 0xBEEF_1234_5678; exactly one mem_we cycle, with scan_phase=0.
3. cpu_stb and vid_stb high together from reset, both reads, held → grant order CPU, VID, CPU, VID; acks never overlap.
4. scan_phase toggling and scan_addr=0x80005 holding 0x0808_xxxx_xxxx → scan_data=0x0808 one cycle after each scan cycle; mem_we is 0 in every scan cycle, including during a write.
5. rst asserted in the WR-wait cycle of a CPU write → no mem_we pulse, no cpu_ack; next transaction completes normally.
6. With SRAM_INIT_EN defined: release rst → words 0x80000..0x8007F equal 0x000008080000; busy falls after exactly 128 slots; a cpu_stb held high during init is acked only after busy falls.
